// File: rtl/fft_peak_sink.sv
// rtl/fft_peak_sink.sv - FFT frame peak-power detector (AXI-Stream sink, one result per frame)
//
// Purpose: consumes one FFT output frame of complex bins and reports the
// index and power (re^2 + im^2) of the strongest bin. A frame ends on tlast
// or after FRAME_LEN bins, whichever comes first. The result is then held
// until the consumer takes it.
//
// Configuration macro: FFT_PEAK_SKIP_DC_EN. When it is defined, bin 0 (DC)
// is left out of the peak search.
//
// Ports:
//   aclk, areset          clock; asynchronous active-high reset
//   s_axis_data_*         bin stream input ({imag, real}, two's complement)
//   peak_bin, peak_pwr    index / unsigned power of the strongest bin
//   frame_err             tlast was early or missing in the reported frame
//   result_valid/ready    result handshake
//   frame_cnt             number of completed (consumed) frames, wraps
module fft_peak_sink #(
  parameter int FRAME_LEN = 2048,
  parameter int DW        = 24
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [2*DW-1:0]              s_axis_data_tdata,
  input  logic                         s_axis_data_tvalid,
  output logic                         s_axis_data_tready,
  input  logic                         s_axis_data_tlast,
  output logic [$clog2(FRAME_LEN)-1:0] peak_bin,
  output logic [2*DW-1:0]              peak_pwr,
  output logic                         frame_err,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic [15:0]                  frame_cnt
);

  localparam int AW = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {COLLECT, DRAIN, HOLD} state_t;

  state_t          r_state;
  logic [1:0]      r_drain_cnt;
  logic [AW-1:0]   r_bin_cnt;
  logic            r_tready;
  logic            r_frame_err;
  logic            r_result_valid;
  logic [15:0]     r_frame_cnt;

  logic signed [DW-1:0] r_s1_re, r_s1_im;
  logic [AW-1:0]        r_s1_idx;
  logic                 r_s1_vld;
  logic [2*DW-1:0]      r_s2_pwr;
  logic [AW-1:0]        r_s2_idx;
  logic                 r_s2_vld;
  logic [AW-1:0]        r_peak_bin;
  logic [2*DW-1:0]      r_peak_pwr;
  logic                 r_peak_loaded;

  logic                 w_accept, w_at_last, w_close, w_release, w_search;
  logic signed [2*DW-1:0] w_re_ext, w_im_ext, w_re_sq, w_im_sq;
  logic [2*DW-1:0]      w_pwr;

  assign w_accept  = s_axis_data_tvalid & r_tready;
  assign w_at_last = (r_bin_cnt == AW'(FRAME_LEN - 1));
  assign w_close   = w_accept & (s_axis_data_tlast | w_at_last);
  assign w_release = r_result_valid & result_ready;

`ifdef FFT_PEAK_SKIP_DC_EN
  assign w_search = (r_bin_cnt != '0);
`else
  assign w_search = 1'b1;
`endif

  // Squares are formed at full 2*DW width so (-2^(DW-1))^2 is exact; the sum
  // of two squares is at most 2^(2*DW-1) and fits unsigned in 2*DW bits.
  assign w_re_ext = {{DW{r_s1_re[DW-1]}}, r_s1_re};
  assign w_im_ext = {{DW{r_s1_im[DW-1]}}, r_s1_im};
  assign w_re_sq  = w_re_ext * w_re_ext;
  assign w_im_sq  = w_im_ext * w_im_ext;
  assign w_pwr    = $unsigned(w_re_sq) + $unsigned(w_im_sq);

  // Frame control. DRAIN covers the three pipeline stages behind the closing
  // beat, so the peak is final by the time result_valid rises.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state        <= COLLECT;
      r_drain_cnt    <= 2'd0;
      r_bin_cnt      <= '0;
      r_tready       <= 1'b0;
      r_frame_err    <= 1'b0;
      r_result_valid <= 1'b0;
      r_frame_cnt    <= 16'd0;
    end else begin
      case (r_state)
        COLLECT: begin
          r_tready <= 1'b1;
          if (w_accept) r_bin_cnt <= r_bin_cnt + AW'(1);
          if (w_close) begin
            r_state     <= DRAIN;
            r_tready    <= 1'b0;
            r_drain_cnt <= 2'd0;
            // Error when tlast and the length limit disagree on where the frame ends.
            r_frame_err <= s_axis_data_tlast ^ w_at_last;
          end
        end
        DRAIN: begin
          if (r_drain_cnt == 2'd2) begin
            r_state        <= HOLD;
            r_result_valid <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + 2'd1;
          end
        end
        HOLD: begin
          if (result_ready) begin
            r_result_valid <= 1'b0;
            r_frame_cnt    <= r_frame_cnt + 16'd1;
            r_state        <= COLLECT;
            r_tready       <= 1'b1;
            r_bin_cnt      <= '0;
            r_frame_err    <= 1'b0;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  // Power pipeline: capture -> square/add -> peak compare.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_s1_vld      <= 1'b0;
      r_s1_re       <= '0;
      r_s1_im       <= '0;
      r_s1_idx      <= '0;
      r_s2_vld      <= 1'b0;
      r_s2_pwr      <= '0;
      r_s2_idx      <= '0;
      r_peak_bin    <= '0;
      r_peak_pwr    <= '0;
      r_peak_loaded <= 1'b0;
    end else begin
      r_s1_vld <= w_accept & w_search;
      r_s1_re  <= s_axis_data_tdata[DW-1:0];
      r_s1_im  <= s_axis_data_tdata[2*DW-1:DW];
      r_s1_idx <= r_bin_cnt;

      r_s2_vld <= r_s1_vld;
      r_s2_pwr <= w_pwr;
      r_s2_idx <= r_s1_idx;

      if (w_release) begin
        r_peak_bin    <= '0;
        r_peak_pwr    <= '0;
        r_peak_loaded <= 1'b0;
      end else if (r_s2_vld && (!r_peak_loaded || (r_s2_pwr > r_peak_pwr))) begin
        // Strict compare: on a tie the earlier (lower) bin is kept.
        r_peak_bin    <= r_s2_idx;
        r_peak_pwr    <= r_s2_pwr;
        r_peak_loaded <= 1'b1;
      end
    end
  end

  assign s_axis_data_tready = r_tready;
  assign peak_bin           = r_peak_bin;
  assign peak_pwr           = r_peak_pwr;
  assign frame_err          = r_frame_err;
  assign result_valid       = r_result_valid;
  assign frame_cnt          = r_frame_cnt;

endmodule

// File: tb/tb_fft_peak_sink.sv
// tb/tb_fft_peak_sink.sv - scoreboard bench for fft_peak_sink
module tb_fft_peak_sink;

  localparam int FL = 2048;
  localparam int DW = 24;

  logic        aclk = 1'b0;
  logic        areset;
  logic [47:0] tdata;
  logic        tvalid, tlast, tready;
  logic [10:0] peak_bin;
  logic [47:0] peak_pwr;
  logic        frame_err, result_valid, result_ready;
  logic [15:0] frame_cnt;

  always #5 aclk = ~aclk;

  fft_peak_sink #(.FRAME_LEN(FL), .DW(DW)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_data_tdata(tdata), .s_axis_data_tvalid(tvalid),
    .s_axis_data_tready(tready), .s_axis_data_tlast(tlast),
    .peak_bin(peak_bin), .peak_pwr(peak_pwr), .frame_err(frame_err),
    .result_valid(result_valid), .result_ready(result_ready),
    .frame_cnt(frame_cnt)
  );

  typedef struct {
    logic [10:0] bin;
    logic [47:0] pwr;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [15:0] exp_cnt = 16'd0;

  int               sp_idx[$];
  logic signed [23:0] sp_re[$];
  logic signed [23:0] sp_im[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int bin, input logic [47:0] pwr, input logic err);
    exp_t e;
    e.bin = bin[10:0];
    e.pwr = pwr;
    e.err = err;
    e.cnt = exp_cnt;
    q.push_back(e);
  endtask

  task automatic add_bin(input int idx, input int re, input int im);
    sp_idx.push_back(idx);
    sp_re.push_back(re[23:0]);
    sp_im.push_back(im[23:0]);
  endtask

  task automatic clear_bins();
    sp_idx.delete();
    sp_re.delete();
    sp_im.delete();
  endtask

  task automatic send_beat(input logic [23:0] re, input logic [23:0] im, input logic last);
    int guard = 0;
    @(negedge aclk);
    tvalid = 1'b1;
    tdata  = {im, re};
    tlast  = last;
    while (!tready && guard < 200) begin
      @(negedge aclk);
      guard++;
    end
    if (guard >= 200) chk("beat_tready_timeout", 64'd0, 64'd1);
    @(posedge aclk);
  endtask

  task automatic send_frame(input int nbeats, input int tl);
    for (int i = 0; i < nbeats; i++) begin
      logic [23:0] re, im;
      re = '0;
      im = '0;
      foreach (sp_idx[k]) if (sp_idx[k] == i) begin
        re = sp_re[k];
        im = sp_im[k];
      end
      send_beat(re, im, i == tl);
    end
  endtask

  // Called right after the closing-beat edge.
  task automatic finish_frame(input int hold, input logic [47:0] hold_data);
    for (int k = 1; k <= 3; k++) begin
      @(posedge aclk);
      #1;
      chk("tready_drain", tready, 0);
      chk($sformatf("rvalid_edge%0d", k), result_valid, k == 3);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    if (hold > 0) begin
      tvalid = 1'b1;
      tdata  = hold_data;
      repeat (hold) begin
        @(posedge aclk);
        #1;
        chk("tready_hold", tready, 0);
        chk("rvalid_hold", result_valid, 1);
      end
      result_ready = 1'b1;
    end
    @(posedge aclk);
    #1;
    chk("rvalid_after_hs", result_valid, 0);
    chk("tready_after_hs", tready, 1);
    chk("frame_cnt_after_hs", frame_cnt, 16'(exp_cnt + 16'd1));
    exp_cnt = exp_cnt + 16'd1;
  endtask

  // Monitor: pops one expectation per result and holds it while result_valid stays high.
  exp_t cur;
  bit   seen = 0;
  bit   have = 0;
  always @(negedge aclk) begin
    if (areset) begin
      seen = 0;
      have = 0;
    end else if (result_valid) begin
      if (!seen) begin
        seen = 1;
        if (q.size() == 0) begin
          have = 0;
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          have = 1;
          cur  = q.pop_front();
        end
      end
      if (have) begin
        chk("peak_bin", peak_bin, cur.bin);
        chk("peak_pwr", peak_pwr, cur.pwr);
        chk("frame_err", frame_err, cur.err);
        chk("frame_cnt", frame_cnt, cur.cnt);
      end
    end else begin
      seen = 0;
      have = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tdata  = '0;
    result_ready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_tready", tready, 0);
    chk("rst_rvalid", result_valid, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_peak_bin", peak_bin, 0);
    chk("rst_peak_pwr", peak_pwr, 0);
    chk("rst_frame_err", frame_err, 0);
    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk);
    #1;
    chk("tready_after_rst", tready, 1);

    // Single peak.
    clear_bins();
    add_bin(100, 1000, -500);
    push_exp(100, 48'd1250000, 1'b0);
    send_frame(FL, FL - 1);
    finish_frame(0, '0);

    // Full-scale negative tie: lower index wins, power exact.
    clear_bins();
    add_bin(5, -8388608, -8388608);
    add_bin(9, -8388608, -8388608);
    push_exp(5, 48'h8000_0000_0000, 1'b0);
    send_frame(FL, FL - 1);
    finish_frame(0, '0);

    // Early tlast at beat 1000.
    clear_bins();
    add_bin(999, 3, 4);
    push_exp(999, 48'd25, 1'b1);
    send_frame(1001, 1000);
    finish_frame(0, '0);

    // Missing tlast: closes on bin 2047, which is still searched.
    clear_bins();
    add_bin(2047, 10, -10);
    push_exp(2047, 48'd200, 1'b1);
    send_frame(FL, -1);
    finish_frame(0, '0);

    // Consumer stalls 50 cycles while the next frame's bin 0 waits.
    clear_bins();
    add_bin(3, 2, -3);
    push_exp(3, 48'd13, 1'b0);
    result_ready = 1'b0;
    send_frame(FL, FL - 1);
    finish_frame(50, {24'd0, 24'd30000});

    // DC bin against a weaker tone.
    clear_bins();
    add_bin(0, 30000, 0);
    add_bin(7, 200, 0);
`ifdef FFT_PEAK_SKIP_DC_EN
    push_exp(7, 48'd40000, 1'b0);
`else
    push_exp(0, 48'd900000000, 1'b0);
`endif
    send_frame(FL, FL - 1);
    finish_frame(0, '0);

    // One-bin frame (early tlast on bin 0).
    clear_bins();
    add_bin(0, 5, 0);
`ifdef FFT_PEAK_SKIP_DC_EN
    push_exp(0, 48'd0, 1'b1);
`else
    push_exp(0, 48'd25, 1'b1);
`endif
    send_frame(1, 0);
    finish_frame(0, '0);

    // Reset in the middle of a frame: no result may appear.
    clear_bins();
    add_bin(10, 50, 50);
    send_frame(600, -1);
    @(negedge aclk);
    tvalid = 1'b0;
    areset = 1'b1;
    #1;
    chk("mid_rst_tready", tready, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    chk("mid_rst_peak_pwr", peak_pwr, 0);
    chk("mid_rst_rvalid", result_valid, 0);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    exp_cnt = 16'd0;
    @(posedge aclk);
    #1;
    chk("tready_after_mid_rst", tready, 1);

    // Clean frame after the abort.
    clear_bins();
    add_bin(2000, -1000, 0);
    push_exp(2000, 48'd1000000, 1'b0);
    send_frame(FL, FL - 1);
    finish_frame(0, '0);

    @(negedge aclk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_peak_sink.md
FFT_PEAK_SINK -- requirements
Module: fft_peak_sink

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 2048, bins per FFT output frame (power of 2, 16..8192).
REQ-002 SHALL have parameter DW, default 24, width of each real/imag component.
REQ-003 aclk  input  1  sole clock; all logic on rising edge.
REQ-004 areset  input  1  asynchronous, active-high reset.
REQ-005 s_axis_data_tdata  input  2*DW  FFT bin; [DW-1:0] real, [2*DW-1:DW] imag, both two's complement.
REQ-006 s_axis_data_tvalid  input  1  bin valid.
REQ-007 s_axis_data_tready  output  1  sink ready.
REQ-008 s_axis_data_tlast  input  1  last bin of frame.
REQ-009 peak_bin  output  log2(FRAME_LEN)  index of maximum-power bin.
REQ-010 peak_pwr  output  2*DW  power of peak bin, unsigned, re^2+im^2.
REQ-011 frame_err  output  1  closing frame had tlast misplaced or missing.
REQ-012 result_valid  output  1  peak_bin/peak_pwr/frame_err valid.
REQ-013 result_ready  input  1  result consumer ready.
REQ-014 frame_cnt  output  16  completed frames, wraps 65535->0.

Function
REQ-015 Beat accepted SHALL mean tvalid & tready on a rising edge; no other bin is used.
REQ-016 FSM states SHALL be COLLECT, DRAIN, HOLD; s_axis_data_tready = 1 only in COLLECT.
REQ-017 Bin index SHALL come from internal beat counter bin_cnt (0 at frame start, +1 per accepted beat), not from data contents.
REQ-018 Frame SHALL close on an accepted beat with tlast=1 or with bin_cnt=FRAME_LEN-1, whichever first; COLLECT->DRAIN on that edge.
REQ-019 frame_err SHALL be set for the frame if tlast=1 with bin_cnt<FRAME_LEN-1 (early) or tlast=0 with bin_cnt=FRAME_LEN-1 (missing).
REQ-020 Power pipeline SHALL be 3 stages: register re/im; square and add (full 2*DW unsigned, no truncation; (-2^(DW-1))^2 exact); compare/update peak.
REQ-021 Peak update SHALL use strict greater-than; ties keep the lowest index; first compared bin always loads.
REQ-022 DRAIN SHALL last exactly 3 cycles; result_valid SHALL rise on the 3rd edge after the closing-beat edge (HOLD entry).
REQ-023 In HOLD, outputs SHALL be stable until result_valid & result_ready; on that edge result_valid->0, frame_cnt+1, state->COLLECT, bin_cnt and peak tracker cleared.
REQ-024 result_ready high before result_valid SHALL have no effect; minimum frame-to-frame gap is 4 cycles of tready low.
REQ-025 tvalid during DRAIN/HOLD SHALL be ignored (backpressured), never dropped or counted.

Reset
REQ-026 areset SHALL asynchronously force: state COLLECT, tready 0 while asserted, bin_cnt 0, peak_bin 0, peak_pwr 0, frame_err 0, result_valid 0, frame_cnt 0, pipeline valids 0.
REQ-027 tready SHALL rise on the first rising edge after areset deasserts.
REQ-028 Reset mid-frame or in HOLD SHALL discard the partial frame/result with no result_valid pulse.

Configuration
REQ-029 Macro FFT_PEAK_SKIP_DC_EN: when defined, bin 0 SHALL be excluded from peak search (first compared bin is 1; a 1-bin frame yields peak_bin 0, peak_pwr 0); when undefined, all bins including 0 SHALL be searched.

Verification
REQ-030 FRAME_LEN=2048 frame, all bins 0 except bin 100 re=1000 im=-500 -> peak_bin=100, peak_pwr=1250000, frame_err=0, result_valid 3 edges after tlast beat.
REQ-031 Bins 5 and 9 both re=-2^23 im=-2^23 -> peak_bin=5, peak_pwr=2^47 exact.
REQ-032 tlast at beat 1000 -> frame closes, frame_err=1; next frame tlast missing at beat 2047 -> closes at 2047, frame_err=1.
REQ-033 result_ready held 0 for 50 cycles with tvalid=1 -> tready=0 throughout, outputs stable, no beats lost; release -> frame_cnt +1, tready 1 next cycle.
REQ-034 bin 0 re=30000, bin 7 re=200 -> with FFT_PEAK_SKIP_DC_EN peak_bin=7 pwr=40000; without peak_bin=0 pwr=900000000.
REQ-035 areset pulsed at beat 600 -> no result_valid; following clean frame reports correctly with frame_cnt=1.
